// File: rtl/fifo_rd_pkg.sv
// Shared definitions for fifo_burst_reader: FSM state encoding and default widths.
package fifo_rd_pkg;

   localparam int unsigned DEF_DATA_WIDTH  = 8;
   localparam int unsigned DEF_LEN_WIDTH   = 8;
   localparam int unsigned BUF_CNT_WIDTH   = 2;
   localparam int unsigned STALL_CNT_WIDTH = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } rd_state_t;

endpackage

// File: rtl/rd_skid_buf.sv
// Two-entry in-order buffer between the FIFO read port and the output stream.
// Each entry carries the data word plus its end-of-burst flag in the MSB.
module rd_skid_buf
   import fifo_rd_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_DATA_WIDTH + 1
)(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_din,
   input  logic                     i_pop,
   output logic [WIDTH-1:0]         o_dout,
   output logic [BUF_CNT_WIDTH-1:0] o_count
);

   logic [WIDTH-1:0]         r_mem [2];
   logic                     r_wptr;
   logic                     r_rptr;
   logic [BUF_CNT_WIDTH-1:0] r_count;

   // Push and pop may coincide; occupancy then stays put while both pointers advance.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_mem[0] <= '0;
         r_mem[1] <= '0;
         r_wptr   <= 1'b0;
         r_rptr   <= 1'b0;
         r_count  <= '0;
      end else begin
         if (i_push) begin
            r_mem[r_wptr] <= i_din;
            r_wptr        <= ~r_wptr;
         end
         if (i_pop) begin
            r_rptr <= ~r_rptr;
         end
         case ({i_push, i_pop})
            2'b10:   r_count <= r_count + BUF_CNT_WIDTH'(1);
            2'b01:   r_count <= r_count - BUF_CNT_WIDTH'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_dout  = r_mem[r_rptr];
   assign o_count = r_count;

endmodule

// File: rtl/fifo_burst_reader.sv
// Reads a burst of len words from a synchronous FIFO and streams them out with valid/ready/last.
// Optional BURST_RD_STATS_EN adds stall_cnt, the number of output back-pressure cycles.
module fifo_burst_reader
   import fifo_rd_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int unsigned LEN_WIDTH  = DEF_LEN_WIDTH
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [LEN_WIDTH-1:0]  len,
   output logic                  busy,
   output logic                  done,
   output logic                  fifo_rd_en,
   input  logic [DATA_WIDTH-1:0] fifo_dout,
   input  logic                  fifo_empty,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_valid,
   output logic                  m_last,
   input  logic                  m_ready
`ifdef BURST_RD_STATS_EN
   ,
   output logic [STALL_CNT_WIDTH-1:0] stall_cnt
`endif
);

   rd_state_t                r_state;
   rd_state_t                w_state_nxt;
   logic [LEN_WIDTH-1:0]     r_len;
   logic [LEN_WIDTH-1:0]     r_issued;
   logic                     r_inflight;
   logic                     r_inflight_last;
   logic                     w_start_ok;
   logic                     w_last_issue;
   logic                     w_pop;
   logic                     w_rd_en;
   logic [BUF_CNT_WIDTH-1:0] w_buf_cnt;
   logic [BUF_CNT_WIDTH-1:0] w_occ;
   logic [DATA_WIDTH:0]      w_head;

   assign w_start_ok   = (r_state == IDLE) && start;
   assign w_last_issue = (r_issued == r_len - LEN_WIDTH'(1));
   assign w_pop        = m_valid && m_ready;
   // Occupancy credit counts this cycle's pop so a steady stream can read every cycle.
   assign w_occ        = w_buf_cnt + BUF_CNT_WIDTH'(r_inflight) - BUF_CNT_WIDTH'(w_pop);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_rd_en     = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_state_nxt = (len != '0) ? RUN : DONE;
            end
         end
         RUN: begin
            w_rd_en = !fifo_empty && (w_occ < BUF_CNT_WIDTH'(2));
            if (w_rd_en && w_last_issue) begin
               w_state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            if (w_pop && m_last) begin
               w_state_nxt = DONE;
            end
         end
         DONE: begin
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // Issue counter wraps modulo 2^LEN_WIDTH; the final read is tagged as it is issued.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_len           <= '0;
         r_issued        <= '0;
         r_inflight      <= 1'b0;
         r_inflight_last <= 1'b0;
      end else begin
         r_inflight      <= w_rd_en;
         r_inflight_last <= w_rd_en && w_last_issue;
         if (w_start_ok) begin
            r_len    <= len;
            r_issued <= '0;
         end else if (w_rd_en) begin
            r_issued <= r_issued + LEN_WIDTH'(1);
         end
      end
   end

   rd_skid_buf #(
      .WIDTH (DATA_WIDTH + 1)
   ) u_buf (
      .clk     (clk),
      .rst     (rst),
      .i_push  (r_inflight),
      .i_din   ({r_inflight_last, fifo_dout}),
      .i_pop   (w_pop),
      .o_dout  (w_head),
      .o_count (w_buf_cnt)
   );

   assign busy       = (r_state != IDLE);
   assign done       = (r_state == DONE);
   assign fifo_rd_en = w_rd_en;
   assign m_valid    = (w_buf_cnt != '0);
   assign m_data     = w_head[DATA_WIDTH-1:0];
   assign m_last     = m_valid && w_head[DATA_WIDTH];

`ifdef BURST_RD_STATS_EN
   logic [STALL_CNT_WIDTH-1:0] r_stall_cnt;

   // Saturating back-pressure counter, restarted by each accepted burst.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_stall_cnt <= '0;
      end else if (w_start_ok) begin
         r_stall_cnt <= '0;
      end else if (m_valid && !m_ready && (r_stall_cnt != '1)) begin
         r_stall_cnt <= r_stall_cnt + STALL_CNT_WIDTH'(1);
      end
   end

   assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader with a synchronous FIFO model and a stream monitor.
// Build with BURST_RD_STATS_EN defined to also check stall_cnt.
module tb_fifo_burst_reader;

   localparam int unsigned DW = 8;
   localparam int unsigned LW = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [LW-1:0] len;
   logic          busy;
   logic          done;
   logic          fifo_rd_en;
   logic [DW-1:0] fifo_dout = '0;
   logic          fifo_empty;
   logic [DW-1:0] m_data;
   logic          m_valid;
   logic          m_last;
   logic          m_ready;
   logic          force_empty;
`ifdef BURST_RD_STATS_EN
   logic [15:0]   stall_cnt;
`endif

   int n_vec = 0;
   int n_err = 0;

   fifo_burst_reader #(
      .DATA_WIDTH (DW),
      .LEN_WIDTH  (LW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .len        (len),
      .busy       (busy),
      .done       (done),
      .fifo_rd_en (fifo_rd_en),
      .fifo_dout  (fifo_dout),
      .fifo_empty (fifo_empty),
      .m_data     (m_data),
      .m_valid    (m_valid),
      .m_last     (m_last),
      .m_ready    (m_ready)
`ifdef BURST_RD_STATS_EN
      ,
      .stall_cnt  (stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   // Synchronous FIFO model: data appears on fifo_dout after the edge that samples fifo_rd_en.
   logic [DW-1:0] fmem [512];
   int wr_idx = 0;
   int rd_idx = 0;

   assign fifo_empty = force_empty || (wr_idx == rd_idx);

   always @(posedge clk) begin
      if (fifo_rd_en && (wr_idx != rd_idx)) begin
         fifo_dout <= fmem[9'(rd_idx)];
         rd_idx    <= rd_idx + 1;
      end
   end

   task automatic push(input logic [DW-1:0] v);
      fmem[9'(wr_idx)] = v;
      wr_idx++;
   endtask

   // Stream monitor, sampled on the falling edge.
   int ncyc = 0;
   always @(posedge clk) ncyc <= ncyc + 1;

   logic [DW-1:0] log_data [$];
   logic          log_last [$];
   int            log_time [$];
   int            done_cnt  = 0;
   int            done_t    = 0;
   int            rd_cnt    = 0;
   int            bad_rd    = 0;
   int            valid_cnt = 0;
   int            unstable  = 0;
   logic          prev_stall = 1'b0;
   logic [DW-1:0] prev_data  = '0;
   logic          prev_last  = 1'b0;

   always @(negedge clk) begin
      if (rst) begin
         prev_stall = 1'b0;
      end else begin
         if (m_valid && m_ready) begin
            log_data.push_back(m_data);
            log_last.push_back(m_last);
            log_time.push_back(ncyc);
         end
         if (done) begin
            done_cnt++;
            done_t = ncyc;
         end
         if (fifo_rd_en) rd_cnt++;
         if (fifo_rd_en && fifo_empty) bad_rd++;
         if (m_valid) valid_cnt++;
         if (prev_stall && (!m_valid || (m_data != prev_data) || (m_last != prev_last))) unstable++;
         prev_stall = m_valid && !m_ready;
         prev_data  = m_data;
         prev_last  = m_last;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic go(input logic [LW-1:0] l, output int t);
      start = 1'b1;
      len   = l;
      @(posedge clk);
      #1;
      t     = ncyc;
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int maxc);
      bit hit;
      hit = 1'b0;
      for (int i = 0; (i < maxc) && !hit; i++) begin
         @(negedge clk);
         hit = done;
      end
      check(tag, 32'(hit), 32'd1);
      @(posedge clk);
      #1;
   endtask

   task automatic check_burst(input string tag, input int base, input int t,
                              input logic [DW-1:0] exp_d [$], input int exp_o [$]);
      check({tag, "_nwords"}, 32'(log_data.size() - base), 32'(exp_d.size()));
      for (int i = 0; i < exp_d.size(); i++) begin
         if (base + i < log_data.size()) begin
            check($sformatf("%s_data%0d", tag, i), 32'(log_data[base+i]), 32'(exp_d[i]));
            check($sformatf("%s_last%0d", tag, i), 32'(log_last[base+i]), 32'(i == exp_d.size() - 1));
            check($sformatf("%s_time%0d", tag, i), 32'(log_time[base+i] - t), 32'(exp_o[i]));
         end
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_busy"},    32'(busy),       32'd0);
      check({tag, "_done"},    32'(done),       32'd0);
      check({tag, "_rd_en"},   32'(fifo_rd_en), 32'd0);
      check({tag, "_m_valid"}, 32'(m_valid),    32'd0);
      check({tag, "_m_last"},  32'(m_last),     32'd0);
      check({tag, "_m_data"},  32'(m_data),     32'd0);
   endtask

   int            t0, bw, bd, brd, bb, bv, bu, nl;
   logic [DW-1:0] ed [$];
   int            eo [$];

   task automatic snap();
      bw  = log_data.size();
      bd  = done_cnt;
      brd = rd_cnt;
      bb  = bad_rd;
      bv  = valid_cnt;
      bu  = unstable;
   endtask

   initial begin
      rst         = 1'b1;
      start       = 1'b0;
      len         = '0;
      m_ready     = 1'b1;
      force_empty = 1'b0;
      @(negedge clk);
      check_reset_outputs("rst0");
      @(posedge clk);
      #1;
      rst = 1'b0;
      step(2);

      // Basic 4-word burst at full throughput
      snap();
      push(8'd11); push(8'd22); push(8'd33); push(8'd44);
      go(8'd4, t0);
      wait_done("t1_done_seen", 20);
      check("t1_done_time", 32'(done_t - t0), 32'd6);
      ed = '{8'd11, 8'd22, 8'd33, 8'd44};
      eo = '{2, 3, 4, 5};
      check_burst("t1", bw, t0, ed, eo);
      check("t1_done_cnt", 32'(done_cnt - bd), 32'd1);
      check("t1_rd_cnt",   32'(rd_cnt - brd),  32'd4);
      @(negedge clk);
      check("t1_idle_busy", 32'(busy), 32'd0);
      @(posedge clk);
      #1;

      // Zero-length burst
      snap();
      go(8'd0, t0);
      @(negedge clk);
      check("t2_done_next", 32'(done), 32'd1);
      check("t2_busy",      32'(busy), 32'd1);
      @(posedge clk);
      #1;
      step(2);
      check("t2_rd_none",    32'(rd_cnt - brd),    32'd0);
      check("t2_valid_none", 32'(valid_cnt - bv),  32'd0);
      check("t2_done_cnt",   32'(done_cnt - bd),   32'd1);

      // Back-pressure for 5 cycles after the first valid word
      snap();
      push(8'hA1); push(8'hA2); push(8'hA3);
      go(8'd3, t0);
      for (int k = 0; k < 15; k++) begin
         m_ready = !((k >= 2) && (k <= 6));
         if (k == 4) begin
            check("t3_hold_valid", 32'(m_valid), 32'd1);
            check("t3_hold_data",  32'(m_data),  32'hA1);
         end
         if (k == 7) begin
            check("t3_rd_stalled", 32'(rd_cnt - brd), 32'd2);
`ifdef BURST_RD_STATS_EN
            check("t3_stall_cnt", 32'(stall_cnt), 32'd5);
`endif
         end
         step(1);
      end
      m_ready = 1'b1;
      ed = '{8'hA1, 8'hA2, 8'hA3};
      eo = '{7, 8, 9};
      check_burst("t3", bw, t0, ed, eo);
      check("t3_done_cnt",  32'(done_cnt - bd), 32'd1);
      check("t3_done_time", 32'(done_t - t0),   32'd10);
      check("t3_unstable",  32'(unstable - bu), 32'd0);
      check("t3_rd_cnt",    32'(rd_cnt - brd),  32'd3);
`ifdef BURST_RD_STATS_EN
      check("t3_stall_hold", 32'(stall_cnt), 32'd5);
`endif

      // FIFO reports empty for 3 cycles mid-burst
      snap();
      push(8'hC1); push(8'hC2); push(8'hC3); push(8'hC4);
      go(8'd4, t0);
      for (int k = 0; k < 15; k++) begin
         force_empty = (k >= 1) && (k <= 3);
         step(1);
      end
      force_empty = 1'b0;
      ed = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
      eo = '{2, 6, 7, 8};
      check_burst("t4", bw, t0, ed, eo);
      check("t4_rd_while_empty", 32'(bad_rd - bb),   32'd0);
      check("t4_rd_cnt",         32'(rd_cnt - brd),  32'd4);
      check("t4_done_cnt",       32'(done_cnt - bd), 32'd1);
      check("t4_done_time",      32'(done_t - t0),   32'd9);

      // Reset mid-burst after 2 of 4 words
      snap();
      push(8'hD1); push(8'hD2);
      go(8'd4, t0);
      step(5);
      check("t5_pre_words", 32'(log_data.size() - bw), 32'd2);
      check("t5_pre_busy",  32'(busy), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      check_reset_outputs("t5_rst");
      @(posedge clk);
      #1;
      rst = 1'b0;
      step(3);
      check("t5_no_done",    32'(done_cnt - bd), 32'd0);
      check("t5_post_busy",  32'(busy), 32'd0);

      // start while busy is ignored
      snap();
      push(8'hE1); push(8'hE2); push(8'hE3);
      go(8'd3, t0);
      for (int k = 0; k < 10; k++) begin
         start = (k >= 1) && (k <= 3);
         len   = start ? 8'd7 : 8'd3;
         step(1);
      end
      start = 1'b0;
      ed = '{8'hE1, 8'hE2, 8'hE3};
      eo = '{2, 3, 4};
      check_burst("t6", bw, t0, ed, eo);
      check("t6_done_cnt",  32'(done_cnt - bd), 32'd1);
      check("t6_done_time", 32'(done_t - t0),   32'd5);
      check("t6_rd_cnt",    32'(rd_cnt - brd),  32'd3);
      @(negedge clk);
      check("t6_idle_busy", 32'(busy), 32'd0);
      @(posedge clk);
      #1;

      // Maximum length burst
      snap();
      for (int i = 0; i < 255; i++) push(DW'(i));
      go(8'd255, t0);
      wait_done("t7_done_seen", 300);
      check("t7_nwords", 32'(log_data.size() - bw), 32'd255);
      nl = 0;
      for (int i = 0; (i < 255) && (bw + i < log_data.size()); i++) begin
         check($sformatf("t7_data%0d", i), 32'(log_data[bw+i]), 32'(i));
         if (log_last[bw+i]) nl++;
      end
      check("t7_last_cnt", 32'(nl), 32'd1);
      if (log_data.size() >= bw + 255) begin
         check("t7_last_pos",  32'(log_last[bw+254]),      32'd1);
         check("t7_last_time", 32'(log_time[bw+254] - t0), 32'd256);
      end
      check("t7_done_time", 32'(done_t - t0),   32'd257);
      check("t7_rd_cnt",    32'(rd_cnt - brd),  32'd255);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
